lbist_ora: RTL and testbench

//   LBIST output response analyzer; sits downstream of the CUT driven by the rpg pattern generator.

---
 rtl/lbist_ora.sv | 118 +++++++++++
 tb/tb_lbist_ora.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lbist_ora.sv
// ----------------------------------------------------------------------------
// lbist_ora -- LBIST output response analyzer
//
// Compacts CUT response words into a Galois MISR on every enabled cycle until
// the pattern generator raises END. It keeps compacting for LAT more cycles so
// that responses still in the CUT pipeline are included. It then compares the
// signature against GOLDEN and reports done/pass to the BIST controller.
//
// Optional feature: define ORA_CYCLE_CNT_EN to add the saturating compaction
// counter and its 'cycles' output port.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous active-high reset
//   en         in   1     compact resp this cycle
//   resp       in   BITS  CUT response word
//   END        in   1     pattern sequence complete
//   signature  out  BITS  current MISR contents
//   done       out  1     test complete, sticky until rst
//   pass       out  1     signature matched GOLDEN (meaningful when done=1)
//   cycles     out  CNTW  MISR steps taken (ORA_CYCLE_CNT_EN only)
// ----------------------------------------------------------------------------
module lbist_ora #(
    parameter int              BITS   = 3,
    parameter logic [BITS-1:0] POLY   = 3'b011,
    parameter logic [BITS-1:0] SEED   = 3'b000,
    parameter logic [BITS-1:0] GOLDEN = 3'b100,
    parameter int              LAT    = 1,
    parameter int              CNTW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [BITS-1:0] resp,
    input  logic            END,
    output logic [BITS-1:0] signature,
    output logic            done,
    output logic            pass
`ifdef ORA_CYCLE_CNT_EN
    ,
    output logic [CNTW-1:0] cycles
`endif
);

    typedef enum logic [1:0] {RUN, FLUSH, CHECK, DONE} state_t;

    // The flush countdown starts at LAT-1 so that exactly LAT edges are spent
    // in FLUSH. With LAT=0 the FLUSH state is never entered.
    localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    state_t          state;
    logic [3:0]      cnt;
    logic [BITS-1:0] misr_nxt;
    logic            step;

    // Galois MISR: shift left, fold the bit leaving the MSB back in through
    // POLY, then XOR in the response word.
    always_comb begin
        misr_nxt = {signature[BITS-2:0], 1'b0}
                 ^ (signature[BITS-1] ? POLY : '0)
                 ^ resp;
    end

    assign step = en && ((state == RUN) || (state == FLUSH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            signature <= SEED;
            done      <= 1'b0;
            pass      <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            if (step)
                signature <= misr_nxt;
            case (state)
                RUN: begin
                    // The END cycle's response is compacted above as usual.
                    if (END) begin
                        if (LAT > 0) begin
                            state <= FLUSH;
                            cnt   <= CNT_INIT;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                FLUSH: begin
                    // The countdown advances whether or not en is set.
                    if (cnt == 4'd0)
                        state <= CHECK;
                    else
                        cnt <= cnt - 4'd1;
                end
                CHECK: begin
                    pass  <= (signature == GOLDEN);
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    // Everything is held until rst.
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef ORA_CYCLE_CNT_EN
    // Steps occur only in RUN/FLUSH, so the counter freezes in CHECK/DONE.
    always_ff @(posedge clk) begin
        if (rst)
            cycles <= '0;
        else if (step && (cycles != {CNTW{1'b1}}))
            cycles <= cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_lbist_ora.sv
// ----------------------------------------------------------------------------
// tb_lbist_ora -- self-checking bench for lbist_ora
//
// Three instances share one stimulus stream:
//   u0  LAT=1 CNTW=8
//   u1  LAT=0 CNTW=8
//   u2  LAT=3 CNTW=2
// Each run is generated up front as whole vectors. The expected output after
// every edge comes from folding the responses in the compaction window. For a
// run whose END first rises at index k, the window is indices 1..k+LAT, and
// done is expected from edge k+LAT+1 onward.
// ----------------------------------------------------------------------------
module tb_lbist_ora;
    localparam logic [2:0] POLY   = 3'b011;
    localparam logic [2:0] SEED   = 3'b000;
    localparam logic [2:0] GOLDEN = 3'b100;
    localparam int         MAXN   = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       end_i = 1'b0;
    logic [2:0] resp = 3'b000;

    logic [2:0] sig_o  [3];
    logic       done_o [3];
    logic       pass_o [3];
`ifdef ORA_CYCLE_CNT_EN
    logic [7:0] cyc0, cyc1;
    logic [1:0] cyc2;
`endif

    int lats  [3] = '{1, 0, 3};
    int cntws [3] = '{8, 8, 2};

    logic       en_v   [MAXN];
    logic       end_v  [MAXN];
    logic [2:0] resp_v [MAXN];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lbist_ora #(.BITS(3), .POLY(POLY), .SEED(SEED), .GOLDEN(GOLDEN), .LAT(1), .CNTW(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .resp(resp), .END(end_i),
        .signature(sig_o[0]), .done(done_o[0]), .pass(pass_o[0])
`ifdef ORA_CYCLE_CNT_EN
        , .cycles(cyc0)
`endif
    );
    lbist_ora #(.BITS(3), .POLY(POLY), .SEED(SEED), .GOLDEN(GOLDEN), .LAT(0), .CNTW(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .resp(resp), .END(end_i),
        .signature(sig_o[1]), .done(done_o[1]), .pass(pass_o[1])
`ifdef ORA_CYCLE_CNT_EN
        , .cycles(cyc1)
`endif
    );
    lbist_ora #(.BITS(3), .POLY(POLY), .SEED(SEED), .GOLDEN(GOLDEN), .LAT(3), .CNTW(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .resp(resp), .END(end_i),
        .signature(sig_o[2]), .done(done_o[2]), .pass(pass_o[2])
`ifdef ORA_CYCLE_CNT_EN
        , .cycles(cyc2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Signature arithmetic as GF(2) polynomials: multiply by x, reduce modulo
    // x^3 + POLY, then add the response word.
    function automatic logic [2:0] mstep(input logic [2:0] s, input logic [2:0] r);
        logic [3:0] p;
        p = {s, 1'b0};
        if (p[3]) p = p ^ {1'b1, POLY};
        return p[2:0] ^ r;
    endfunction

    function automatic logic [2:0] fold(input int upto);
        logic [2:0] s;
        s = SEED;
        for (int i = 1; i <= upto; i++)
            if (en_v[i]) s = mstep(s, resp_v[i]);
        return s;
    endfunction

    function automatic int nsteps(input int upto);
        int c;
        c = 0;
        for (int i = 1; i <= upto; i++)
            if (en_v[i]) c++;
        return c;
    endfunction

`ifdef ORA_CYCLE_CNT_EN
    function automatic logic [31:0] cyc_of(input int d);
        if (d == 0) return 32'(cyc0);
        if (d == 1) return 32'(cyc1);
        return 32'(cyc2);
    endfunction
`endif

    // Reset edge first, then len stimulus edges. END first rises at index kk.
    // A run shorter than kk+LAT+1 is aborted by the next run's reset.
    task automatic run(input int len, input int kk, input string name);
        int last, m, cmax;
        logic de;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_rst_sig_u%0d", name, d), 32'(sig_o[d]), 32'(SEED));
            chk($sformatf("%s_rst_done_u%0d", name, d), 32'(done_o[d]), 32'd0);
            chk($sformatf("%s_rst_pass_u%0d", name, d), 32'(pass_o[d]), 32'd0);
`ifdef ORA_CYCLE_CNT_EN
            chk($sformatf("%s_rst_cyc_u%0d", name, d), cyc_of(d), 32'd0);
`endif
        end
        rst = 1'b0;
        for (int t = 1; t <= len; t++) begin
            en = en_v[t]; resp = resp_v[t]; end_i = end_v[t];
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                last = kk + lats[d];
                m    = (t < last) ? t : last;
                de   = (t > last);
                chk($sformatf("%s_t%0d_sig_u%0d", name, t, d), 32'(sig_o[d]), 32'(fold(m)));
                chk($sformatf("%s_t%0d_done_u%0d", name, t, d), 32'(done_o[d]), 32'(de));
                chk($sformatf("%s_t%0d_pass_u%0d", name, t, d), 32'(pass_o[d]),
                    32'(de && (fold(last) == GOLDEN)));
`ifdef ORA_CYCLE_CNT_EN
                cmax = (1 << cntws[d]) - 1;
                chk($sformatf("%s_t%0d_cyc_u%0d", name, t, d), cyc_of(d),
                    32'((nsteps(m) < cmax) ? nsteps(m) : cmax));
`else
                cmax = 0;
`endif
            end
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < MAXN; i++) begin
            en_v[i] = 1'b1; resp_v[i] = 3'b001; end_v[i] = (i == 3);
        end
    endtask

    initial begin
        int kk, len;

        // Directed: en=1, resp=001, END at edge 3
        load_basic();
        run(9, 3, "t1");
        chk("t1_u0_final_sig", 32'(sig_o[0]), 32'h4);
        chk("t1_u0_pass", 32'(pass_o[0]), 32'd1);
        chk("t1_u1_final_sig", 32'(sig_o[1]), 32'h7);
        chk("t1_u1_pass", 32'(pass_o[1]), 32'd0);
`ifdef ORA_CYCLE_CNT_EN
        chk("t1_u0_cycles", 32'(cyc0), 32'd4);
        chk("t1_u2_cycles_sat", 32'(cyc2), 32'd3);
`endif

        // Bad response on the 2nd compaction
        load_basic(); resp_v[2] = 3'b011;
        run(7, 3, "t2");
        chk("t2_u0_pass", 32'(pass_o[0]), 32'd0);

        // en dropped on the 2nd cycle
        load_basic(); en_v[2] = 1'b0;
        run(7, 3, "t4");
        chk("t4_u0_final_sig", 32'(sig_o[0]), 32'h7);
        chk("t4_u0_pass", 32'(pass_o[0]), 32'd0);

        // END at the very first edge, held high afterwards
        load_basic();
        for (int i = 1; i < MAXN; i++) end_v[i] = 1'b1;
        run(7, 1, "tend1");

        // Abort while u0 is in FLUSH, then rerun of test 1
        load_basic();
        run(3, 3, "t5a");
        load_basic();
        run(6, 3, "t5b");
        chk("t5_u0_pass", 32'(pass_o[0]), 32'd1);

        // Randomised runs, some aborted before completion
        for (int r = 0; r < 40; r++) begin
            kk  = $urandom_range(1, 10);
            len = $urandom_range(1, kk + 7);
            for (int i = 0; i < MAXN; i++) begin
                en_v[i]   = ($urandom_range(0, 3) != 0);
                resp_v[i] = 3'($urandom);
                end_v[i]  = (i < kk) ? 1'b0 : (i == kk) ? 1'b1 : 1'($urandom);
            end
            run(len, kk, $sformatf("r%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
